// File: rtl/ldr_avalon_master.sv
// Avalon-MM initiator that runs the Levinson-Durbin slave: soft reset, R load,
// start, done poll, settle delay and coefficient readout streamed to the LPC stage.
module ldr_avalon_master #(
  parameter int READ_LATENCY  = 1,
  parameter int SETTLE_CYCLES = 5,
  parameter int POLL_TIMEOUT  = 65535,
  parameter int ORDER         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_wr,
  input  logic [3:0]  r_idx,
  input  logic [15:0] r_data,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        a_valid,
  output logic [3:0]  a_idx,
  output logic [15:0] a_data,
  output logic [15:0] avm_address,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  output logic        avm_read,
  input  logic [15:0] avm_readdata
);

  localparam int PW = $clog2(POLL_TIMEOUT + 2);
  localparam int SW = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic [3:0] {
    IDLE, WR_RST, WR_RCLR, WR_R, WR_START, WR_SCLR, POLL_RD, POLL_WAIT,
    SETTLE, RD_A, RD_WAIT, FIN, ERR
  } state_t;

  state_t          state;
  logic [15:0]     r_buf [ORDER+1];
  logic [3:0]      idx;
  logic [2:0]      lat_cnt;
  logic [PW-1:0]   poll_cnt;
  logic [SW-1:0]   settle_cnt;
  logic [3:0]      r_sel;
  logic [15:0]     r_fwd;

  function automatic logic [15:0] r_addr(input logic [3:0] k);
    return 16'h0030 + {8'h00, k, 4'h0};
  endfunction

  // A2 onwards skip the 0x100 slot.
  function automatic logic [15:0] a_addr(input logic [3:0] k);
    logic [3:0] km2;
    km2 = k - 4'd2;
    if (k < 4'd2)
      return 16'h00E0 + {8'h00, k, 4'h0};
    else
      return 16'h0110 + {8'h00, km2, 4'h0};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ORDER; i++) r_buf[i] <= '0;
    end else if (r_wr && r_idx <= 4'(ORDER)) begin
      r_buf[r_idx] <= r_data;
    end
  end

  // Forward a same-cycle R write so the word put on the bus is never stale.
  always_comb begin
    r_sel = (state == WR_R) ? idx + 4'd1 : 4'd0;
    if (r_sel > 4'(ORDER)) r_sel = 4'd0;
    r_fwd = (r_wr && r_idx == r_sel) ? r_data : r_buf[r_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      a_valid       <= 1'b0;
      a_idx         <= '0;
      a_data        <= '0;
      avm_address   <= '0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      idx           <= '0;
      lat_cnt       <= '0;
      poll_cnt      <= '0;
      settle_cnt    <= '0;
    end else begin
      avm_write <= 1'b0;
      avm_read  <= 1'b0;
      done      <= 1'b0;
      a_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            busy          <= 1'b1;
            err           <= 1'b0;
            state         <= WR_RST;
            avm_write     <= 1'b1;
            avm_address   <= 16'h0000;
            avm_writedata <= 16'h0001;
          end
        end
        WR_RST: begin
          state         <= WR_RCLR;
          avm_write     <= 1'b1;
          avm_address   <= 16'h0000;
          avm_writedata <= 16'h0000;
        end
        WR_RCLR: begin
          state         <= WR_R;
          idx           <= 4'd0;
          avm_write     <= 1'b1;
          avm_address   <= r_addr(4'd0);
          avm_writedata <= r_fwd;
        end
        WR_R: begin
          avm_write <= 1'b1;
          if (idx == 4'(ORDER)) begin
            state         <= WR_START;
            avm_address   <= 16'h0010;
            avm_writedata <= 16'h0001;
          end else begin
            idx           <= idx + 4'd1;
            avm_address   <= r_addr(idx + 4'd1);
            avm_writedata <= r_fwd;
          end
        end
        WR_START: begin
          state         <= WR_SCLR;
          avm_write     <= 1'b1;
          avm_address   <= 16'h0010;
          avm_writedata <= 16'h0000;
        end
        WR_SCLR: begin
          state       <= POLL_RD;
          poll_cnt    <= '0;
          avm_read    <= 1'b1;
          avm_address <= 16'h0020;
        end
        POLL_RD: begin
          state   <= POLL_WAIT;
          lat_cnt <= 3'd1;
        end
        POLL_WAIT: begin
          if (lat_cnt != 3'(READ_LATENCY)) begin
            lat_cnt <= lat_cnt + 3'd1;
          end else if (avm_readdata != 16'h0000) begin
            idx <= 4'd0;
            if (SETTLE_CYCLES == 0) begin
              state       <= RD_A;
              avm_read    <= 1'b1;
              avm_address <= a_addr(4'd0);
            end else begin
              state      <= SETTLE;
              settle_cnt <= SW'(1);
            end
          end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
            state <= ERR;
          end else begin
            poll_cnt    <= poll_cnt + PW'(1);
            state       <= POLL_RD;
            avm_read    <= 1'b1;
            avm_address <= 16'h0020;
          end
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES)) begin
            state       <= RD_A;
            avm_read    <= 1'b1;
            avm_address <= a_addr(idx);
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        RD_A: begin
          state   <= RD_WAIT;
          lat_cnt <= 3'd1;
        end
        RD_WAIT: begin
          if (lat_cnt != 3'(READ_LATENCY)) begin
            lat_cnt <= lat_cnt + 3'd1;
          end else begin
            a_valid <= 1'b1;
            a_idx   <= idx;
            a_data  <= avm_readdata;
            if (idx == 4'(ORDER)) begin
              state <= FIN;
            end else begin
              idx         <= idx + 4'd1;
              state       <= RD_A;
              avm_read    <= 1'b1;
              avm_address <= a_addr(idx + 4'd1);
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          err   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldr_avalon_master.sv
// Randomized bench: two masters (latency 1 / latency 3 with short timeout) against
// a behavioural slave; traces are compared with a cycle schedule built from the bus rules.
`timescale 1ns/1ps
module tb_ldr_avalon_master;
  localparam int NU     = 2;
  localparam int ORD    = 10;
  localparam int SETTLE = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [NU];
  logic        r_wr [NU];
  logic [3:0]  r_idx [NU];
  logic [15:0] r_data [NU];
  logic        go [NU];
  logic        busy [NU];
  logic        done [NU];
  logic        err [NU];
  logic        a_valid [NU];
  logic [3:0]  a_idx [NU];
  logic [15:0] a_data [NU];
  logic [15:0] avm_address [NU];
  logic        avm_write [NU];
  logic [15:0] avm_writedata [NU];
  logic        avm_read [NU];
  logic [15:0] avm_readdata [NU];

  generate
    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
      ldr_avalon_master #(
        .READ_LATENCY (gi == 0 ? 1 : 3),
        .SETTLE_CYCLES(SETTLE),
        .POLL_TIMEOUT (gi == 0 ? 65535 : 8),
        .ORDER        (ORD)
      ) dut (
        .clk          (clk),
        .rst          (rst[gi]),
        .r_wr         (r_wr[gi]),
        .r_idx        (r_idx[gi]),
        .r_data       (r_data[gi]),
        .go           (go[gi]),
        .busy         (busy[gi]),
        .done         (done[gi]),
        .err          (err[gi]),
        .a_valid      (a_valid[gi]),
        .a_idx        (a_idx[gi]),
        .a_data       (a_data[gi]),
        .avm_address  (avm_address[gi]),
        .avm_write    (avm_write[gi]),
        .avm_writedata(avm_writedata[gi]),
        .avm_read     (avm_read[gi]),
        .avm_readdata (avm_readdata[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int tmo_of(input int u);
    return (u == 0) ? 65535 : 8;
  endfunction

  function automatic logic [15:0] a_addr_m(input int k);
    if (k == 0) return 16'h00E0;
    if (k == 1) return 16'h00F0;
    return 16'(32'h110 + 32'h10 * (k - 2));
  endfunction

  // ---------------- slave model ----------------
  int          poll_n [NU] = '{0, 0};
  int          done_after [NU];
  logic [15:0] a_mem [NU][11];
  logic [15:0] pipe [NU][4];

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) begin
      logic [15:0] resp;
      resp = 16'($urandom);
      if (avm_write[u] && avm_address[u] == 16'h0000 && avm_writedata[u] == 16'h0001)
        poll_n[u] = 0;
      if (avm_read[u]) begin
        resp = 16'hBAD0;
        if (avm_address[u] == 16'h0020) begin
          poll_n[u] = poll_n[u] + 1;
          resp = (done_after[u] != 0 && poll_n[u] >= done_after[u]) ?
                 16'($urandom_range(1, 65535)) : 16'h0000;
        end
        for (int k = 0; k <= ORD; k++)
          if (avm_address[u] == a_addr_m(k)) resp = a_mem[u][k];
      end
      for (int s = 3; s > 0; s--) pipe[u][s] <= pipe[u][s-1];
      pipe[u][0] <= resp;
    end
  end

  always_comb begin
    avm_readdata[0] = pipe[0][0];
    avm_readdata[1] = pipe[1][2];
  end

  // ---------------- monitor ----------------
  typedef struct packed {
    logic [28:0] cyc;
    logic [1:0]  u;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } tx_t;

  int  cyc = 0;
  tx_t tr_q[$];
  tx_t av_q[$];
  tx_t dn_q[$];
  int  overlap_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      tx_t e;
      e.cyc = 29'(cyc);
      e.u   = 2'(u);
      if (avm_write[u] && avm_read[u]) overlap_n = overlap_n + 1;
      if (avm_write[u] || avm_read[u]) begin
        e.wr   = avm_write[u];
        e.addr = avm_address[u];
        e.data = avm_write[u] ? avm_writedata[u] : 16'h0000;
        tr_q.push_back(e);
      end
      if (a_valid[u]) begin
        e.wr   = 1'b0;
        e.addr = {12'h000, a_idx[u]};
        e.data = a_data[u];
        av_q.push_back(e);
      end
      if (done[u]) begin
        e.wr   = 1'b0;
        e.addr = 16'h0000;
        e.data = 16'h0000;
        dn_q.push_back(e);
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_r [NU][11];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs(input int u);
    return {busy[u], done[u], err[u], a_valid[u], a_idx[u], a_data[u],
            avm_address[u], avm_write[u], avm_writedata[u], avm_read[u]};
  endfunction

  task automatic write_r(input int u, input int k, input logic [15:0] d);
    r_wr[u]   = 1'b1;
    r_idx[u]  = 4'(k);
    r_data[u] = d;
    tick();
    r_wr[u] = 1'b0;
    if (k <= ORD) model_r[u][k] = d;
  endtask

  task automatic clear_logs();
    tr_q.delete();
    av_q.delete();
    dn_q.delete();
    overlap_n = 0;
  endtask

  task automatic run(input int u, input int n_done, input bit co_wr, input bit extra_go);
    int go_cyc, L, T, P, k, wait_n, t, n100;
    bit exp_err;
    logic [15:0] rr [11];
    tx_t e;
    tx_t exp_tr[$];
    tx_t exp_av[$];
    L = lat_of(u);
    T = tmo_of(u);
    done_after[u] = n_done;
    clear_logs();
    go[u]  = 1'b1;
    go_cyc = cyc;
    if (co_wr) begin
      k = $urandom_range(0, ORD);
      r_wr[u]   = 1'b1;
      r_idx[u]  = 4'(k);
      r_data[u] = 16'($urandom);
      model_r[u][k] = r_data[u];
    end
    for (int i = 0; i <= ORD; i++) rr[i] = model_r[u][i];
    tick();
    go[u]   = 1'b0;
    r_wr[u] = 1'b0;
    check_eq($sformatf("u%0d busy_after_go", u), 64'(busy[u]), 64'd1);
    check_eq($sformatf("u%0d err_cleared_by_go", u), 64'(err[u]), 64'd0);
    wait_n = 0;
    while (busy[u] && wait_n < 3000) begin
      go[u] = (extra_go && (wait_n == 5 || wait_n == 25)) ? 1'b1 : 1'b0;
      tick();
      wait_n++;
    end
    go[u] = 1'b0;
    check_eq($sformatf("u%0d run_bounded", u), 64'(wait_n < 3000), 64'd1);
    repeat (4) tick();

    // expected schedule
    e.u = 2'(u);
    t = go_cyc + 1;
    e.wr = 1'b1;
    e.cyc = 29'(t); e.addr = 16'h0000; e.data = 16'h0001; exp_tr.push_back(e); t++;
    e.cyc = 29'(t); e.addr = 16'h0000; e.data = 16'h0000; exp_tr.push_back(e); t++;
    for (int i = 0; i <= ORD; i++) begin
      e.cyc = 29'(t); e.addr = 16'(32'h30 + 32'h10 * i); e.data = rr[i]; exp_tr.push_back(e); t++;
    end
    e.cyc = 29'(t); e.addr = 16'h0010; e.data = 16'h0001; exp_tr.push_back(e); t++;
    e.cyc = 29'(t); e.addr = 16'h0010; e.data = 16'h0000; exp_tr.push_back(e); t++;
    exp_err = (n_done == 0 || n_done > T);
    P = exp_err ? T : n_done;
    e.wr = 1'b0;
    e.data = 16'h0000;
    for (int i = 0; i < P; i++) begin
      e.cyc = 29'(t); e.addr = 16'h0020; exp_tr.push_back(e);
      t = t + L + 1;
    end
    if (!exp_err) begin
      t = t + SETTLE;
      for (int j = 0; j <= ORD; j++) begin
        e.cyc = 29'(t); e.addr = a_addr_m(j); e.data = 16'h0000; exp_tr.push_back(e);
        e.cyc = 29'(t + L + 1); e.addr = 16'(j); e.data = a_mem[u][j]; exp_av.push_back(e);
        t = t + L + 1;
      end
    end

    check_eq($sformatf("u%0d trace_len", u), 64'(tr_q.size()), 64'(exp_tr.size()));
    for (int i = 0; i < tr_q.size() && i < exp_tr.size(); i++)
      check_eq($sformatf("u%0d tx%0d", u, i), tr_q[i], exp_tr[i]);
    check_eq($sformatf("u%0d a_valid_count", u), 64'(av_q.size()), 64'(exp_av.size()));
    for (int i = 0; i < av_q.size() && i < exp_av.size(); i++)
      check_eq($sformatf("u%0d coef%0d", u, i), av_q[i], exp_av[i]);
    if (!exp_err) begin
      check_eq($sformatf("u%0d done_count", u), 64'(dn_q.size()), 64'd1);
      if (dn_q.size() > 0)
        check_eq($sformatf("u%0d done_cycle", u), 64'(dn_q[0].cyc), 64'(t + 1));
    end else begin
      check_eq($sformatf("u%0d done_count_err", u), 64'(dn_q.size()), 64'd0);
    end
    check_eq($sformatf("u%0d err_final", u), 64'(err[u]), 64'(exp_err));
    check_eq($sformatf("u%0d busy_final", u), 64'(busy[u]), 64'd0);
    check_eq($sformatf("u%0d rw_overlap", u), 64'(overlap_n), 64'd0);
    n100 = 0;
    foreach (tr_q[i]) if (tr_q[i].addr == 16'h0100) n100++;
    check_eq($sformatf("u%0d addr_0x100", u), 64'(n100), 64'd0);
    $display("run u=%0d polls_to_done=%0d txns=%0d coefs=%0d err=%0b", u, n_done, tr_q.size(), av_q.size(), err[u]);
  endtask

  task automatic load_random_r(input int u);
    for (int k = 0; k <= ORD; k++) write_r(u, k, 16'($urandom));
  endtask

  task automatic fill_random_a(input int u);
    for (int k = 0; k <= ORD; k++) a_mem[u][k] = 16'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] plan_r [11];
    plan_r = '{16'sd32767, 16'sd25742, 16'sd16169, 16'sd9836, 16'sd4569, -16'sd2674,
               -16'sd11249, -16'sd17338, -16'sd14853, -16'sd6828, -16'sd3174};
    for (int u = 0; u < NU; u++) begin
      rst[u] = 1'b1; go[u] = 1'b0; r_wr[u] = 1'b0; r_idx[u] = '0; r_data[u] = '0;
      done_after[u] = 0;
      for (int k = 0; k <= ORD; k++) begin
        model_r[u][k] = '0;
        a_mem[u][k] = '0;
      end
    end
    repeat (3) tick();
    for (int u = 0; u < NU; u++)
      check_eq($sformatf("u%0d reset_outputs", u), outs(u), 64'd0);
    for (int u = 0; u < NU; u++) rst[u] = 1'b0;
    tick();

    // reference sequence: fixed R, done after 40 polls, A[k]=0x1000+k
    for (int k = 0; k <= ORD; k++) write_r(0, k, plan_r[k]);
    for (int k = 0; k <= ORD; k++) a_mem[0][k] = 16'(32'h1000 + k);
    run(0, 40, 1'b0, 1'b0);

    // out-of-range R index must not disturb the buffer
    write_r(0, 13, 16'h7777);
    for (int it = 0; it < 3; it++) begin
      load_random_r(0);
      fill_random_a(0);
      run(0, $urandom_range(1, 50), it == 1, it == 2);
    end

    // latency 3, timeout 8
    load_random_r(1);
    fill_random_a(1);
    run(1, $urandom_range(1, 7), 1'b0, 1'b0);
    fill_random_a(1);
    run(1, 8, 1'b0, 1'b1);
    run(1, 0, 1'b0, 1'b0);
    fill_random_a(1);
    run(1, 3, 1'b1, 1'b0);

    // reset in the middle of polling
    done_after[0] = 40;
    clear_logs();
    go[0] = 1'b1;
    tick();
    go[0] = 1'b0;
    repeat (30) tick();
    #2 rst[0] = 1'b1;
    #1 check_eq("u0 rst_async_outputs", outs(0), 64'd0);
    tick();
    tick();
    rst[0] = 1'b0;
    for (int k = 0; k <= ORD; k++) model_r[0][k] = '0;
    clear_logs();
    repeat (30) tick();
    check_eq("u0 quiet_after_rst_bus", 64'(tr_q.size()), 64'd0);
    check_eq("u0 quiet_after_rst_avalid", 64'(av_q.size()), 64'd0);
    check_eq("u0 quiet_after_rst_done", 64'(dn_q.size()), 64'd0);
    fill_random_a(0);
    run(0, 2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
